mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single unified instruction/data memory port between the IF stage (fetch) and the MEM stage (load/store).
- One access at a time. Data has priority; a streak counter stops fetch from starving.
- Drives the memory port through a ready handshake with a timeout.
- Produces per-stage ack pulses and stall signals, which the pipeline control ORs with the hazard-unit stall.

Parameters:
ADDR_W, 16, memory address width
DATA_W, 16, memory data width
MAX_DATA_STREAK, 3, max consecutive data grants while a fetch is pending
TIMEOUT, 15, max cycles in an access state without mem_ready before abort (counter width $clog2(TIMEOUT+1))

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
if_req  in  1  fetch request; held until if_ack or if_err
if_addr  in  ADDR_W  fetch address
if_rdata  out  DATA_W  fetched word, valid while if_ack=1
if_ack  out  1  one-cycle fetch completion pulse
dm_req  in  1  data request; held until dm_ack or dm_err
dm_we  in  1  1=store, 0=load
dm_addr  in  ADDR_W  data address
dm_wdata  in  DATA_W  store data
dm_rdata  out  DATA_W  load data, valid while dm_ack=1
dm_ack  out  1  one-cycle data completion pulse
if_err  out  1  one-cycle fetch timeout pulse
dm_err  out  1  one-cycle data timeout pulse
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid with mem_ready
mem_ready  in  1  memory completes the current access this cycle
stall_if  out  1  if_req & ~if_ack & ~if_err (combinational)
stall_mem  out  1  dm_req & ~dm_ack & ~dm_err (combinational)

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, all acks/errs=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, if_rdata=0, dm_rdata=0, streak=0, timer=0.
- States: IDLE, IF_ACC, DM_ACC.
- IDLE arbitration:
  - A requester whose ack or err is high this cycle is treated as not requesting.
  - dm_req & (~if_req | streak<MAX_DATA_STREAK) -> DM_ACC.
  - else if_req -> IF_ACC.
  - else stay in IDLE.
- Grant registers mem_addr, mem_we (dm_we, or 0 for fetch) and mem_wdata. These stay stable for the whole access.
- In IF_ACC / DM_ACC:
  - mem_en=1; timer increments each cycle.
  - On mem_ready: next cycle state=IDLE, the granted ack=1, rdata <= mem_rdata (stores also capture; the value is don't-care), mem_en=0, timer=0.
- Timeout: if timer==TIMEOUT and mem_ready=0, next cycle state=IDLE, the granted err=1, rdata unchanged, mem_en=0.
  - mem_ready on the TIMEOUT cycle itself counts as success.
- Latency: minimum 3 cycles from req to ack when mem_ready is returned in the first access cycle (grant cycle, access cycle, ack cycle).
- Throughput: a new grant may occur in the ack cycle, for the other requester only.
- Streak counter, updated at each grant:
  - DM grant with if_req=1: streak+1, saturating at MAX_DATA_STREAK.
  - DM grant with if_req=0: streak=0.
  - IF grant: streak=0.
- mem_we=0 whenever mem_en=0.
- Requests arriving mid-access wait; they are not queued beyond the req level.
- Requester changes to addr/wdata during an access are ignored.
- Deasserting a req mid-access does not abort it. The ack is still pulsed and the requester ignores it.
- rst_n low mid-access: everything returns to reset values immediately. No ack or err is issued for the aborted access.
- No combinational path from mem_ready to any output; only stall_* depend combinationally on inputs.

Test Plan:
- Fetch only: if_req=1, if_addr=0x0040, mem_ready=1 on the 2nd access cycle with mem_rdata=0x1234 -> mem_en high 2 cycles with mem_addr=0x0040, mem_we=0; then if_ack=1 with if_rdata=0x1234; stall_if=1 until that cycle.
- Simultaneous requests: if_req and dm_req (store, addr 0x0100, wdata 0xBEEF) both set, mem_ready immediate -> DM granted first with mem_we=1, mem_wdata=0xBEEF; IF granted in the dm_ack cycle; if_ack 2 cycles after dm_ack.
- Starvation: dm_req held continuously (re-presented after each ack) with if_req=1 -> exactly 3 DM accesses, then 1 IF access, then DM resumes.
- Timeout: dm_req=1 load, mem_ready never asserted -> mem_en high for 16 cycles, then dm_err pulse; dm_ack stays 0; dm_rdata unchanged; state returns to IDLE.
- Reset mid-access: assert rst_n=0 during IF_ACC -> mem_en=0 and if_ack=0 asynchronously. After release with if_req still 1, a fresh grant occurs.
- Back-to-back loads: dm_req reissued in the cycle after dm_ack, if_req=0 -> the next grant occurs in that cycle, and the streak counter stays 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbiter sharing one unified memory port between instruction fetch and data access.
// Data wins ties; a saturating streak counter hands the port to a waiting fetch.
module mem_arbiter #(
  parameter int unsigned ADDR_W          = 16,
  parameter int unsigned DATA_W          = 16,
  parameter int unsigned MAX_DATA_STREAK = 3,
  parameter int unsigned TIMEOUT         = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ack,
  output logic              if_err,
  output logic              dm_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              stall_if,
  output logic              stall_mem
);

  localparam int unsigned TimerW  = $clog2(TIMEOUT + 1);
  localparam int unsigned StreakW = $clog2(MAX_DATA_STREAK + 1);

  typedef enum logic [1:0] {StIdle, StIfAcc, StDmAcc} state_e;

  state_e              state_q, state_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic [StreakW-1:0]  streak_q, streak_d;
  logic                if_ack_q, if_ack_d;
  logic                dm_ack_q, dm_ack_d;
  logic                if_err_q, if_err_d;
  logic                dm_err_q, dm_err_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;

  // A requester finishing this cycle must not be granted again on its stale request level.
  logic if_req_eff, dm_req_eff;
  assign if_req_eff = if_req & ~if_ack_q & ~if_err_q;
  assign dm_req_eff = dm_req & ~dm_ack_q & ~dm_err_q;

  logic streak_full;
  assign streak_full = (streak_q >= StreakW'(MAX_DATA_STREAK));

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    streak_d    = streak_q;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;
    if_err_d    = 1'b0;
    dm_err_d    = 1'b0;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;

    unique case (state_q)
      StIdle: begin
        if (dm_req_eff && (!if_req_eff || !streak_full)) begin
          state_d     = StDmAcc;
          mem_en_d    = 1'b1;
          mem_we_d    = dm_we;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          timer_d     = '0;
          if (!if_req_eff) begin
            streak_d = '0;
          end else if (!streak_full) begin
            streak_d = streak_q + StreakW'(1);
          end
        end else if (if_req_eff) begin
          state_d     = StIfAcc;
          mem_en_d    = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
          timer_d     = '0;
          streak_d    = '0;
        end
      end

      StIfAcc, StDmAcc: begin
        if (mem_ready) begin
          state_d  = StIdle;
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
          timer_d  = '0;
          if (state_q == StIfAcc) begin
            if_ack_d   = 1'b1;
            if_rdata_d = mem_rdata;
          end else begin
            dm_ack_d   = 1'b1;
            dm_rdata_d = mem_rdata;
          end
        end else if (timer_q == TimerW'(TIMEOUT)) begin
          state_d  = StIdle;
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
          timer_d  = '0;
          if (state_q == StIfAcc) begin
            if_err_d = 1'b1;
          end else begin
            dm_err_d = 1'b1;
          end
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      timer_q     <= '0;
      streak_q    <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      if_err_q    <= 1'b0;
      dm_err_q    <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      streak_q    <= streak_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
      if_err_q    <= if_err_d;
      dm_err_q    <= dm_err_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

  assign if_ack    = if_ack_q;
  assign dm_ack    = dm_ack_q;
  assign if_err    = if_err_q;
  assign dm_err    = dm_err_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;

  assign stall_if  = if_req & ~if_ack_q & ~if_err_q;
  assign stall_mem = dm_req & ~dm_ack_q & ~dm_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, priority, starvation guard, timeout, reset, back-to-back.
`timescale 1ns/1ps
module tb_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [15:0] if_addr;
  logic [15:0] if_rdata;
  logic        if_ack;
  logic        dm_req;
  logic        dm_we;
  logic [15:0] dm_addr;
  logic [15:0] dm_wdata;
  logic [15:0] dm_rdata;
  logic        dm_ack;
  logic        if_err;
  logic        dm_err;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ready;
  logic        stall_if;
  logic        stall_mem;

  int nvec;
  int nfail;

  mem_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_ack    (if_ack),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_rdata  (dm_rdata),
    .dm_ack    (dm_ack),
    .if_err    (if_err),
    .dm_err    (dm_err),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .stall_if  (stall_if),
    .stall_mem (stall_mem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1ns after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    if_req    = 1'b0;
    if_addr   = '0;
    dm_req    = 1'b0;
    dm_we     = 1'b0;
    dm_addr   = '0;
    dm_wdata  = '0;
    mem_rdata = '0;
    mem_ready = 1'b0;
    rst_n     = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    logic [15:0] outs_or;
    do_reset();
    outs_or = mem_addr | mem_wdata | if_rdata | dm_rdata;
    nvec++;
    if ({if_ack, dm_ack, if_err, dm_err, mem_en, mem_we} !== 6'b0) begin
      nfail++;
      $display("FAIL reset_flags: got %b, want 000000",
               {if_ack, dm_ack, if_err, dm_err, mem_en, mem_we});
    end
    nvec++;
    if (outs_or !== 16'h0) begin
      nfail++;
      $display("FAIL reset_data: or of addr/wdata/rdatas got %h, want 0000", outs_or);
    end
    nvec++;
    if ({stall_if, stall_mem} !== 2'b00) begin
      nfail++;
      $display("FAIL reset_stall: got %b, want 00", {stall_if, stall_mem});
    end
  endtask

  task automatic test_fetch_only();
    do_reset();
    if_req  = 1'b1;
    if_addr = 16'h0040;
    #1;
    nvec++;
    if (stall_if !== 1'b1) begin
      nfail++;
      $display("FAIL fetch_stall_req: got %b, want 1", stall_if);
    end
    step();
    nvec++;
    if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 16'h0040}) begin
      nfail++;
      $display("FAIL fetch_acc1: en/we/addr got %b/%b/%h, want 1/0/0040", mem_en, mem_we, mem_addr);
    end
    step();
    mem_ready = 1'b1;
    mem_rdata = 16'h1234;
    nvec++;
    if ({mem_en, mem_we, mem_addr, stall_if, if_ack} !== {1'b1, 1'b0, 16'h0040, 1'b1, 1'b0}) begin
      nfail++;
      $display("FAIL fetch_acc2: en/we/addr/stall/ack got %b/%b/%h/%b/%b, want 1/0/0040/1/0",
               mem_en, mem_we, mem_addr, stall_if, if_ack);
    end
    step();
    nvec++;
    if ({if_ack, if_rdata, mem_en, stall_if} !== {1'b1, 16'h1234, 1'b0, 1'b0}) begin
      nfail++;
      $display("FAIL fetch_ack: ack/rdata/en/stall got %b/%h/%b/%b, want 1/1234/0/0",
               if_ack, if_rdata, mem_en, stall_if);
    end
    if_req    = 1'b0;
    mem_ready = 1'b0;
    step();
    nvec++;
    if ({if_ack, mem_en} !== 2'b00) begin
      nfail++;
      $display("FAIL fetch_after: ack/en got %b, want 00", {if_ack, mem_en});
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    if_req    = 1'b1;
    if_addr   = 16'h0080;
    dm_req    = 1'b1;
    dm_we     = 1'b1;
    dm_addr   = 16'h0100;
    dm_wdata  = 16'hBEEF;
    mem_ready = 1'b1;
    mem_rdata = 16'h1111;
    step();
    nvec++;
    if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 16'h0100, 16'hBEEF}) begin
      nfail++;
      $display("FAIL sim_dm_grant: en/we/addr/wdata got %b/%b/%h/%h, want 1/1/0100/BEEF",
               mem_en, mem_we, mem_addr, mem_wdata);
    end
    step();
    nvec++;
    if ({dm_ack, if_ack, mem_en, mem_we} !== 4'b1000) begin
      nfail++;
      $display("FAIL sim_dm_ack: dm_ack/if_ack/en/we got %b, want 1000",
               {dm_ack, if_ack, mem_en, mem_we});
    end
    dm_req    = 1'b0;
    mem_rdata = 16'h2222;
    step();
    nvec++;
    if ({mem_en, mem_we, mem_addr, if_ack} !== {1'b1, 1'b0, 16'h0080, 1'b0}) begin
      nfail++;
      $display("FAIL sim_if_grant: en/we/addr/ack got %b/%b/%h/%b, want 1/0/0080/0",
               mem_en, mem_we, mem_addr, if_ack);
    end
    step();
    nvec++;
    if ({if_ack, if_rdata} !== {1'b1, 16'h2222}) begin
      nfail++;
      $display("FAIL sim_if_ack: ack/rdata got %b/%h, want 1/2222", if_ack, if_rdata);
    end
    if_req    = 1'b0;
    mem_ready = 1'b0;
    step();
  endtask

  // The fetch side withdraws its request only in data-ack cycles, so every data grant sees a
  // pending fetch and the streak guard decides.
  task automatic test_starvation();
    logic [15:0] grants [8];
    int          ng;
    logic        prev_en;
    logic [15:0] exp_g [5];
    exp_g[0] = 16'h0300;
    exp_g[1] = 16'h0300;
    exp_g[2] = 16'h0300;
    exp_g[3] = 16'h0200;
    exp_g[4] = 16'h0300;
    ng = 0;
    do_reset();
    dm_req    = 1'b1;
    dm_we     = 1'b0;
    dm_addr   = 16'h0300;
    if_req    = 1'b1;
    if_addr   = 16'h0200;
    mem_ready = 1'b1;
    prev_en   = 1'b0;
    for (int c = 0; c < 24; c++) begin
      step();
      if_req = ~dm_ack;
      if (mem_en && !prev_en && ng < 8) begin
        grants[ng] = mem_addr;
        ng++;
      end
      prev_en = mem_en;
    end
    nvec++;
    if (ng < 5) begin
      nfail++;
      $display("FAIL starve_count: got %0d grants, want at least 5", ng);
    end else begin
      for (int i = 0; i < 5; i++) begin
        nvec++;
        if (grants[i] !== exp_g[i]) begin
          nfail++;
          $display("FAIL starve_grant%0d: addr got %h, want %h", i, grants[i], exp_g[i]);
        end
      end
    end
    dm_req    = 1'b0;
    if_req    = 1'b0;
    mem_ready = 1'b0;
    step();
    step();
  endtask

  task automatic test_timeout();
    int cnt;
    int acks;
    logic [15:0] addr_seen;
    do_reset();
    dm_req    = 1'b1;
    dm_we     = 1'b0;
    dm_addr   = 16'h0400;
    mem_ready = 1'b1;
    mem_rdata = 16'h5A5A;
    step();
    step();
    nvec++;
    if ({dm_ack, dm_rdata} !== {1'b1, 16'h5A5A}) begin
      nfail++;
      $display("FAIL to_preload: ack/rdata got %b/%h, want 1/5A5A", dm_ack, dm_rdata);
    end
    dm_req    = 1'b0;
    mem_ready = 1'b0;
    step();
    dm_req    = 1'b1;
    dm_addr   = 16'h0402;
    mem_rdata = 16'hFFFF;
    step();
    cnt       = 0;
    acks      = 0;
    addr_seen = mem_addr;
    while (mem_en === 1'b1 && cnt < 40) begin
      cnt++;
      if (dm_ack !== 1'b0) acks++;
      if (cnt == 5) dm_addr = 16'h0FFF;
      addr_seen = mem_addr;
      step();
    end
    nvec++;
    if (cnt != 16) begin
      nfail++;
      $display("FAIL to_en_cycles: got %0d, want 16", cnt);
    end
    nvec++;
    if (addr_seen !== 16'h0402) begin
      nfail++;
      $display("FAIL to_addr_stable: got %h, want 0402", addr_seen);
    end
    nvec++;
    if ({dm_err, dm_ack, dm_rdata, stall_mem} !== {1'b1, 1'b0, 16'h5A5A, 1'b0} || acks != 0) begin
      nfail++;
      $display("FAIL to_err: err/ack/rdata/stall got %b/%b/%h/%b acks %0d, want 1/0/5A5A/0 acks 0",
               dm_err, dm_ack, dm_rdata, stall_mem, acks);
    end
    dm_req = 1'b0;
    step();
    nvec++;
    if ({dm_err, mem_en} !== 2'b00) begin
      nfail++;
      $display("FAIL to_idle: err/en got %b, want 00", {dm_err, mem_en});
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    if_req  = 1'b1;
    if_addr = 16'h0600;
    step();
    nvec++;
    if (mem_en !== 1'b1) begin
      nfail++;
      $display("FAIL rmid_grant: en got %b, want 1", mem_en);
    end
    #2;
    rst_n = 1'b0;
    #1;
    nvec++;
    if ({mem_en, if_ack, mem_addr} !== {1'b0, 1'b0, 16'h0000}) begin
      nfail++;
      $display("FAIL rmid_async: en/ack/addr got %b/%b/%h, want 0/0/0000", mem_en, if_ack, mem_addr);
    end
    step();
    rst_n = 1'b1;
    step();
    nvec++;
    if ({mem_en, mem_addr, if_ack, if_err} !== {1'b1, 16'h0600, 1'b0, 1'b0}) begin
      nfail++;
      $display("FAIL rmid_regrant: en/addr/ack/err got %b/%h/%b/%b, want 1/0600/0/0",
               mem_en, mem_addr, if_ack, if_err);
    end
    mem_ready = 1'b1;
    mem_rdata = 16'h0C0C;
    step();
    nvec++;
    if ({if_ack, if_rdata} !== {1'b1, 16'h0C0C}) begin
      nfail++;
      $display("FAIL rmid_ack: ack/rdata got %b/%h, want 1/0C0C", if_ack, if_rdata);
    end
    if_req    = 1'b0;
    mem_ready = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    do_reset();
    dm_req    = 1'b1;
    dm_we     = 1'b0;
    dm_addr   = 16'h0700;
    mem_ready = 1'b1;
    mem_rdata = 16'h0A0A;
    step();
    nvec++;
    if ({mem_en, mem_addr} !== {1'b1, 16'h0700}) begin
      nfail++;
      $display("FAIL b2b_grant1: en/addr got %b/%h, want 1/0700", mem_en, mem_addr);
    end
    step();
    nvec++;
    if ({dm_ack, dm_rdata, mem_en} !== {1'b1, 16'h0A0A, 1'b0}) begin
      nfail++;
      $display("FAIL b2b_ack1: ack/rdata/en got %b/%h/%b, want 1/0A0A/0", dm_ack, dm_rdata, mem_en);
    end
    dm_req    = 1'b0;
    dm_addr   = 16'h0702;
    mem_rdata = 16'h0B0B;
    step();
    dm_req = 1'b1;
    nvec++;
    if ({mem_en, dm_ack} !== 2'b00) begin
      nfail++;
      $display("FAIL b2b_gap: en/ack got %b, want 00", {mem_en, dm_ack});
    end
    step();
    nvec++;
    if ({mem_en, mem_addr} !== {1'b1, 16'h0702}) begin
      nfail++;
      $display("FAIL b2b_grant2: en/addr got %b/%h, want 1/0702", mem_en, mem_addr);
    end
    step();
    nvec++;
    if ({dm_ack, dm_rdata} !== {1'b1, 16'h0B0B}) begin
      nfail++;
      $display("FAIL b2b_ack2: ack/rdata got %b/%h, want 1/0B0B", dm_ack, dm_rdata);
    end
    dm_req    = 1'b0;
    mem_ready = 1'b0;
    step();
  endtask

  initial begin
    nvec  = 0;
    nfail = 0;
    test_reset();
    test_fetch_only();
    test_simultaneous();
    test_starvation();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
